// File: rtl/sr_fifo_pkg.sv
// Shared default sizing and flag thresholds for the synchronous FIFO family.
package sr_fifo_pkg;

  localparam int unsigned DATA_WIDTH_DEF    = 32;
  localparam int unsigned ADDR_WIDTH_DEF    = 3;
  localparam int unsigned FWFT_DEF          = 0;
  localparam int unsigned AEMPTY_THRESH_DEF = 1;

  // almost_full defaults to one entry short of full for any depth
  function automatic int unsigned afull_thresh_def(input int unsigned addr_width);
    return (32'd1 << addr_width) - 32'd1;
  endfunction

endpackage

// File: rtl/fifo_mem_dp.sv
// Dual-port FIFO storage: one synchronous write port, one asynchronous read port, no reset.
module fifo_mem_dp #(
  parameter int unsigned DW = 32,
  parameter int unsigned AW = 3
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data_c
);

  localparam int unsigned DEPTH = 32'd1 << AW;

  logic [DW-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  assign rd_data_c = mem_q[rd_addr];

endmodule

// File: rtl/param_fifo.sv
// Parameterised synchronous FIFO: pointer/count/flag control around a dual-port memory,
// with registered-read or first-word-fall-through output.
module param_fifo
  import sr_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = DATA_WIDTH_DEF,
  parameter int unsigned ADDR_WIDTH    = ADDR_WIDTH_DEF,
  parameter int unsigned FWFT          = FWFT_DEF,
  parameter int unsigned AFULL_THRESH  = afull_thresh_def(ADDR_WIDTH),
  parameter int unsigned AEMPTY_THRESH = AEMPTY_THRESH_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  write_enable,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic                  read_enable,
  output logic [DATA_WIDTH-1:0] read_data,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int unsigned CW    = ADDR_WIDTH + 1;
  localparam int unsigned DEPTH = 32'd1 << ADDR_WIDTH;

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  full_q, full_d;
  logic                  empty_q, empty_d;
  logic                  afull_q, afull_d;
  logic                  aempty_q, aempty_d;
  logic                  ovf_q, ovf_d;
  logic                  udf_q, udf_d;

  logic                  rd_acc_c;
  logic                  wr_acc_c;
  logic [DATA_WIDTH-1:0] mem_rd_data_c;

  // A write into a full FIFO is still accepted when a read frees the head slot
  assign rd_acc_c = read_enable && !empty_q;
  assign wr_acc_c = write_enable && (!full_q || rd_acc_c);

  fifo_mem_dp #(
    .DW (DATA_WIDTH),
    .AW (ADDR_WIDTH)
  ) u_mem (
    .clk       (clk),
    .wr_en     (wr_acc_c && reset),
    .wr_addr   (wr_ptr_q),
    .wr_data   (write_data),
    .rd_addr   (rd_ptr_q),
    .rd_data_c (mem_rd_data_c)
  );

  // Next-state: pointers, occupancy, output data and flags computed from next count
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    rdata_d  = rdata_q;

    if (rd_acc_c) begin
      rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
      rdata_d  = mem_rd_data_c;
    end
    if (wr_acc_c) begin
      wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
    end

    unique case ({wr_acc_c, rd_acc_c})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    full_d   = (count_d == CW'(DEPTH));
    empty_d  = (count_d == '0);
    afull_d  = (32'(count_d) >= AFULL_THRESH);
    aempty_d = (32'(count_d) <= AEMPTY_THRESH);
    ovf_d    = write_enable && !wr_acc_c;
    udf_d    = read_enable && !rd_acc_c;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      rdata_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      rdata_q  <= rdata_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      afull_q  <= afull_d;
      aempty_q <= aempty_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  // FWFT presents the head entry straight from storage; forced to zero while empty
  if (FWFT != 0) begin : g_fwft
    assign read_data = empty_q ? '0 : mem_rd_data_c;
  end else begin : g_regread
    assign read_data = rdata_q;
  end

  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = afull_q;
  assign almost_empty = aempty_q;
  assign count        = count_q;
  assign overflow     = ovf_q;
  assign underflow    = udf_q;

endmodule

// File: tb/tb_param_fifo.sv
// Scoreboard bench for param_fifo: a registered-read and a FWFT instance share stimulus,
// a queue-based reference model predicts state, a negedge monitor compares.
module tb_param_fifo;

  localparam int unsigned DW    = 32;
  localparam int unsigned AW    = 3;
  localparam int unsigned DEPTH = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          write_enable = 1'b0;
  logic [DW-1:0] write_data = '0;
  logic          read_enable = 1'b0;

  logic [DW-1:0] rd0, rd1;
  logic          full0, empty0, af0, ae0, ov0, un0;
  logic          full1, empty1, af1, ae1, ov1, un1;
  logic [AW:0]   cnt0, cnt1;

  param_fifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FWFT(0)) u_dut (
    .clk(clk), .reset(reset), .write_enable(write_enable), .write_data(write_data),
    .read_enable(read_enable), .read_data(rd0), .full(full0), .empty(empty0),
    .almost_full(af0), .almost_empty(ae0), .count(cnt0), .overflow(ov0), .underflow(un0)
  );

  param_fifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FWFT(1)) u_dut_fwft (
    .clk(clk), .reset(reset), .write_enable(write_enable), .write_data(write_data),
    .read_enable(read_enable), .read_data(rd1), .full(full1), .empty(empty1),
    .almost_full(af1), .almost_empty(ae1), .count(cnt1), .overflow(ov1), .underflow(un1)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    int          cnt;
    logic        full;
    logic        empty;
    logic        af;
    logic        ae;
    logic        ov;
    logic        un;
    logic [31:0] rd;
    logic        fw_vld;
    logic [31:0] fw;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] model[$];
  logic [31:0] last_rd = '0;
  int          cyc = 0;
  int          errors = 0;
  int          checks = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d got=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  // One stimulus cycle: drive inputs, advance the reference queue, queue the expectation
  task automatic step(input logic rst_n, input logic we, input logic [31:0] wd, input logic re);
    exp_t e;
    int   n;
    logic rd_ok, wr_ok;
    @(posedge clk);
    #1;
    reset        = rst_n;
    write_enable = we;
    write_data   = wd;
    read_enable  = re;
    n     = model.size();
    rd_ok = re && (n != 0);
    wr_ok = we && ((n != DEPTH) || rd_ok);
    if (!rst_n) begin
      model.delete();
      last_rd = '0;
      e.ov = 1'b0;
      e.un = 1'b0;
    end else begin
      if (rd_ok) last_rd = model.pop_front();
      if (wr_ok) model.push_back(wd);
      e.ov = we && !wr_ok;
      e.un = re && !rd_ok;
    end
    n        = model.size();
    e.due    = cyc + 1;
    e.cnt    = n;
    e.full   = (n == DEPTH);
    e.empty  = (n == 0);
    e.af     = (n >= DEPTH - 1);
    e.ae     = (n <= 1);
    e.rd     = last_rd;
    e.fw_vld = (n != 0);
    e.fw     = (n != 0) ? model[0] : '0;
    sb.push_back(e);
  endtask

  // Monitor: compares both instances against each due expectation
  always @(negedge clk) begin
    exp_t e;
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      e = sb.pop_front();
      chk("count",        32'(cnt0),   32'(e.cnt));
      chk("full",         32'(full0),  32'(e.full));
      chk("empty",        32'(empty0), 32'(e.empty));
      chk("almost_full",  32'(af0),    32'(e.af));
      chk("almost_empty", 32'(ae0),    32'(e.ae));
      chk("overflow",     32'(ov0),    32'(e.ov));
      chk("underflow",    32'(un0),    32'(e.un));
      chk("read_data",    rd0,         e.rd);
      chk("fwft_count",   32'(cnt1),   32'(e.cnt));
      chk("fwft_empty",   32'(empty1), 32'(e.empty));
      chk("fwft_full",    32'(full1),  32'(e.full));
      chk("fwft_ovf_udf", 32'({ov1, un1}), 32'({e.ov, e.un}));
      if (e.fw_vld) chk("fwft_read_data", rd1, e.fw);
    end
  end

  initial begin
    int pw;
    step(1'b0, 1'b0, '0, 1'b0);
    step(1'b0, 1'b0, '0, 1'b0);

    // Fill with 1..8, overflow on the ninth, drain, then underflow
    for (int i = 1; i <= 8; i++) step(1'b1, 1'b1, 32'(i), 1'b0);
    step(1'b1, 1'b1, 32'h99, 1'b0);
    step(1'b1, 1'b0, '0, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, '0, 1'b1);
    step(1'b1, 1'b0, '0, 1'b1);
    step(1'b1, 1'b0, '0, 1'b0);

    // Full pass-through: simultaneous read/write at count 8, 0xA5 emerges last
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 32'h10 + 32'(i), 1'b0);
    step(1'b1, 1'b1, 32'hA5, 1'b1);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, '0, 1'b1);
    step(1'b1, 1'b0, '0, 1'b0);

    // Write with read on empty, FWFT head visible without a read, then pop
    step(1'b1, 1'b1, 32'h11, 1'b1);
    step(1'b1, 1'b0, '0, 1'b0);
    step(1'b1, 1'b0, '0, 1'b1);
    step(1'b1, 1'b0, '0, 1'b0);

    // Reset mid-operation with a concurrent write, then fresh data round-trips
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 32'hC0 + 32'(i), 1'b0);
    step(1'b0, 1'b1, 32'hDEAD, 1'b0);
    step(1'b1, 1'b1, 32'h77, 1'b0);
    step(1'b1, 1'b0, '0, 1'b1);
    step(1'b1, 1'b0, '0, 1'b0);

    // Randomised traffic alternating fill-biased and drain-biased phases
    for (int i = 0; i < 600; i++) begin
      pw = ((i / 40) % 2 == 0) ? 75 : 30;
      step(($urandom_range(99) != 0),
           ($urandom_range(99) < pw),
           $urandom,
           ($urandom_range(99) < (100 - pw)));
    end
    step(1'b1, 1'b0, '0, 1'b0);
    step(1'b1, 1'b0, '0, 1'b0);

    repeat (3) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain pending=%0d expected=0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
